// File: rtl/seg_display_arbiter_pkg.sv
// Shared types and constants for the seven-segment display arbiter.
// The display is eight hex digits fed by 32-bit values with 8-bit digit masks.
package seg_disp_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      HOLD    = 2'd1,
      RELEASE = 2'd2
   } state_t;

   localparam int DISP_DIGITS   = 8;
   localparam int DISP_W        = 32;
   localparam int DEFAULT_DWELL = 1000000;

endpackage

// File: rtl/seg_display_arbiter_rr_priority_pick.sv
// Round-robin picker: first set request at or after rr_ptr, wrapping circularly.
// The request vector is doubled so the wrap-around search becomes a plain lowest-bit scan.
module rr_priority_pick #(
   parameter int N  = 4,
   parameter int IW = 2
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] rr_ptr,
   output logic [N-1:0]  pick,
   output logic [IW-1:0] index,
   output logic          valid
);

   localparam int DW = 2 * N;

   logic [DW-1:0] dbl;
   logic [DW-1:0] masked;
   int            pos;

   always_comb begin
      dbl    = {req, req};
      masked = dbl & ~((DW'(1) << rr_ptr) - DW'(1));
      valid  = 1'b0;
      pos    = 0;
      // Scan downward so the lowest set bit at or above rr_ptr wins.
      for (int p = DW - 1; p >= 0; p--) begin
         if (masked[p]) begin
            valid = 1'b1;
            pos   = p;
         end
      end
      index = (pos >= N) ? IW'(pos - N) : IW'(pos);
   end

   generate
      for (genvar gi = 0; gi < N; gi++) begin : g_pick
         assign pick[gi] = valid && (index == IW'(gi));
      end
   endgenerate

endmodule

// File: rtl/seg_display_arbiter.sv
// Shares the 8-digit seven-segment display between NUM_REQ producers with
// round-robin fairness and a minimum dwell per owner under contention.
module seg_display_arbiter
   import seg_disp_pkg::*;
#(
   parameter int NUM_REQ      = 4,
   parameter int DWELL_CYCLES = DEFAULT_DWELL,
   parameter int CNT_W        = 20,
   localparam int OW          = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [NUM_REQ-1:0]            req,
   input  logic [NUM_REQ*DISP_W-1:0]     req_data,
   input  logic [NUM_REQ*DISP_DIGITS-1:0] req_mask,
   output logic [NUM_REQ-1:0]            grant,
   output logic [NUM_REQ-1:0]            done,
   output logic [OW-1:0]                 owner,
   output logic [DISP_W-1:0]             disp_value,
   output logic [DISP_DIGITS-1:0]        disp_mask,
   output logic                          disp_load
);

   state_t                 state_q, state_d;
   logic [OW-1:0]          rr_ptr_q, rr_ptr_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [NUM_REQ-1:0]     grant_q, grant_d;
   logic [NUM_REQ-1:0]     done_q, done_d;
   logic [OW-1:0]          owner_q, owner_d;
   logic [DISP_W-1:0]      disp_value_q, disp_value_d;
   logic [DISP_DIGITS-1:0] disp_mask_q, disp_mask_d;
   logic                   disp_load_q, disp_load_d;

   logic [DISP_W-1:0]      data_arr [NUM_REQ];
   logic [DISP_DIGITS-1:0] mask_arr [NUM_REQ];

   generate
      for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
         assign data_arr[gi] = req_data[gi*DISP_W +: DISP_W];
         assign mask_arr[gi] = req_mask[gi*DISP_DIGITS +: DISP_DIGITS];
      end
   endgenerate

   logic [NUM_REQ-1:0] pick_onehot;
   logic [OW-1:0]      pick_idx;
   logic               pick_valid;

   rr_priority_pick #(
      .N  (NUM_REQ),
      .IW (OW)
   ) u_pick (
      .req    (req),
      .rr_ptr (rr_ptr_q),
      .pick   (pick_onehot),
      .index  (pick_idx),
      .valid  (pick_valid)
   );

   logic [DISP_W-1:0]      owner_data;
   logic [DISP_DIGITS-1:0] owner_mask;
   logic                   owner_req;
   logic                   others_pending;
   logic                   hold_expired;
   logic                   leave_hold;
   logic [OW-1:0]          next_ptr;

   assign owner_data     = data_arr[owner_q];
   assign owner_mask     = mask_arr[owner_q];
   assign owner_req      = req[owner_q];
   assign others_pending = |(req & ~grant_q);
   assign hold_expired   = (cnt_q == '0);
   // Dropping the request waives the dwell; expiry only yields if someone else waits.
   assign leave_hold     = !owner_req || (hold_expired && others_pending);
   assign next_ptr       = (owner_q == OW'(NUM_REQ - 1)) ? '0 : owner_q + OW'(1);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         rr_ptr_q     <= '0;
         cnt_q        <= '0;
         grant_q      <= '0;
         done_q       <= '0;
         owner_q      <= '0;
         disp_value_q <= '0;
         disp_mask_q  <= '0;
         disp_load_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         rr_ptr_q     <= rr_ptr_d;
         cnt_q        <= cnt_d;
         grant_q      <= grant_d;
         done_q       <= done_d;
         owner_q      <= owner_d;
         disp_value_q <= disp_value_d;
         disp_mask_q  <= disp_mask_d;
         disp_load_q  <= disp_load_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (pick_valid) state_d = HOLD;
         HOLD:    if (leave_hold) state_d = RELEASE;
         RELEASE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      grant_d      = grant_q;
      done_d       = '0;
      owner_d      = owner_q;
      disp_value_d = disp_value_q;
      disp_mask_d  = disp_mask_q;
      disp_load_d  = 1'b0;
      rr_ptr_d     = rr_ptr_q;
      cnt_d        = cnt_q;
      case (state_q)
         IDLE: begin
            grant_d = '0;
            if (pick_valid) begin
               grant_d      = pick_onehot;
               owner_d      = pick_idx;
               disp_value_d = data_arr[pick_idx];
               disp_mask_d  = mask_arr[pick_idx];
               disp_load_d  = 1'b1;
               cnt_d        = CNT_W'(DWELL_CYCLES - 1);
            end
         end
         HOLD: begin
            disp_value_d = owner_data;
            disp_mask_d  = owner_mask;
            disp_load_d  = (owner_data != disp_value_q) || (owner_mask != disp_mask_q);
            if (leave_hold) begin
               grant_d  = '0;
               done_d   = grant_q;
               rr_ptr_d = next_ptr;
            end else begin
               cnt_d = hold_expired ? CNT_W'(DWELL_CYCLES - 1) : cnt_q - CNT_W'(1);
            end
         end
         default: grant_d = '0;
      endcase
   end

   assign grant      = grant_q;
   assign done       = done_q;
   assign owner      = owner_q;
   assign disp_value = disp_value_q;
   assign disp_mask  = disp_mask_q;
   assign disp_load  = disp_load_q;

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Directed bench for seg_display_arbiter with a cycle model checked on every clock.
module tb_seg_display_arbiter;

   localparam int N     = 4;
   localparam int DWELL = 8;

   logic         clk;
   logic         reset;
   logic [N-1:0] req;
   logic [N*32-1:0] req_data;
   logic [N*8-1:0]  req_mask;
   logic [N-1:0] grant;
   logic [N-1:0] done;
   logic [1:0]   owner;
   logic [31:0]  disp_value;
   logic [7:0]   disp_mask;
   logic         disp_load;

   seg_display_arbiter #(
      .NUM_REQ      (N),
      .DWELL_CYCLES (DWELL),
      .CNT_W        (4)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .req        (req),
      .req_data   (req_data),
      .req_mask   (req_mask),
      .grant      (grant),
      .done       (done),
      .owner      (owner),
      .disp_value (disp_value),
      .disp_mask  (disp_mask),
      .disp_load  (disp_load)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Model: phase 0 = nobody granted, 1 = granted, 2 = handing back.
   logic [N-1:0] m_grant = '0;
   logic [N-1:0] m_done  = '0;
   logic [1:0]   m_owner = '0;
   logic [31:0]  m_value = '0;
   logic [7:0]   m_mask  = '0;
   logic         m_load  = 1'b0;
   int           m_phase = 0;
   int           m_age   = 0;
   int           m_ptr   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_step();
      int found;
      int others;
      logic [31:0] nv;
      logic [7:0]  nm;
      if (reset) begin
         m_grant = '0; m_done = '0; m_owner = '0; m_value = '0; m_mask = '0;
         m_load = 1'b0; m_phase = 0; m_age = 0; m_ptr = 0;
         return;
      end
      m_load = 1'b0;
      m_done = '0;
      case (m_phase)
         0: begin
            found = -1;
            for (int k = 0; k < N; k++)
               if (found < 0 && req[(m_ptr + k) % N]) found = (m_ptr + k) % N;
            if (found >= 0) begin
               m_grant = 4'b0001 << found;
               m_owner = 2'(found);
               m_value = req_data[found*32 +: 32];
               m_mask  = req_mask[found*8 +: 8];
               m_load  = 1'b1;
               m_phase = 1;
               m_age   = 0;
            end
         end
         1: begin
            nv = req_data[int'(m_owner)*32 +: 32];
            nm = req_mask[int'(m_owner)*8 +: 8];
            m_load  = (nv != m_value) || (nm != m_mask);
            m_value = nv;
            m_mask  = nm;
            others  = 0;
            for (int k = 0; k < N; k++)
               if (k != int'(m_owner) && req[k]) others = 1;
            if (!req[m_owner] || ((m_age % DWELL) == DWELL - 1 && others != 0)) begin
               m_done  = 4'b0001 << m_owner;
               m_grant = '0;
               m_ptr   = (int'(m_owner) + 1) % N;
               m_phase = 2;
            end else begin
               m_age++;
            end
         end
         default: m_phase = 0;
      endcase
   endtask

   task automatic compare_all();
      chk("grant", 32'(grant), 32'(m_grant));
      chk("done", 32'(done), 32'(m_done));
      chk("owner", 32'(owner), 32'(m_owner));
      chk("disp_value", disp_value, m_value);
      chk("disp_mask", 32'(disp_mask), 32'(m_mask));
      chk("disp_load", 32'(disp_load), 32'(m_load));
      chk("grant_onehot0", 32'($onehot0(grant)), 32'd1);
      chk("done_and_grant", 32'(done & grant), 32'd0);
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      @(negedge clk);
      compare_all();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      req   = '0;
      tick();
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      req   = 4'b1111;
      for (int i = 0; i < N; i++) begin
         req_data[i*32 +: 32] = 32'h1111_1111 * (i + 1);
         req_mask[i*8 +: 8]   = 8'hF0 | 8'(i);
      end

      // Reset held with all requests pending, then first grant.
      repeat (3) begin
         tick();
         chk("s1_rst_grant", 32'(grant), 32'd0);
         chk("s1_rst_done", 32'(done), 32'd0);
         chk("s1_rst_value", disp_value, 32'd0);
         chk("s1_rst_mask", 32'(disp_mask), 32'd0);
      end
      reset = 1'b0;
      tick();
      chk("s1_first_grant", 32'(grant), 32'b0001);
      $display("scenario 1: reset and first grant");

      // Single requester holds indefinitely.
      do_reset();
      req_data[31:0] = 32'h0000_00A5;
      req_mask[7:0]  = 8'h03;
      req = 4'b0001;
      tick();
      chk("s2_grant", 32'(grant), 32'b0001);
      chk("s2_owner", 32'(owner), 32'd0);
      chk("s2_value", disp_value, 32'h0000_00A5);
      chk("s2_mask", 32'(disp_mask), 32'h03);
      chk("s2_load", 32'(disp_load), 32'd1);
      repeat (40) begin
         tick();
         chk("s2_hold_done", 32'(done), 32'd0);
         chk("s2_hold_load", 32'(disp_load), 32'd0);
      end
      req = '0;
      tick();
      chk("s2_release_done", 32'(done), 32'b0001);
      tick();
      $display("scenario 2: single owner hold");

      // Two simultaneous requests.
      do_reset();
      req = 4'b0101;
      for (int c = 0; c < DWELL; c++) begin
         tick();
         chk("s3_grant0", 32'(grant), 32'b0001);
      end
      tick();
      chk("s3_rel_grant", 32'(grant), 32'd0);
      chk("s3_rel_done", 32'(done), 32'b0001);
      tick();
      chk("s3_idle_grant", 32'(grant), 32'd0);
      chk("s3_idle_done", 32'(done), 32'd0);
      tick();
      chk("s3_grant2", 32'(grant), 32'b0100);
      chk("s3_owner2", 32'(owner), 32'd2);
      $display("scenario 3: two-way contention");

      // Full contention rotates 0,1,2,3,0 with a 10-cycle period.
      do_reset();
      req = 4'b1111;
      for (int t = 1; t <= 50; t++) begin
         int p;
         int o;
         p = (t - 1) % 10;
         o = ((t - 1) / 10) % 4;
         tick();
         chk("s4_grant", 32'(grant), (p < 8) ? (32'd1 << o) : 32'd0);
         chk("s4_done", 32'(done), (p == 8) ? (32'd1 << o) : 32'd0);
      end
      $display("scenario 4: four-way rotation");

      // Owner 1 drops early while requester 3 waits.
      do_reset();
      req = 4'b1010;
      tick();
      chk("s5_grant1", 32'(grant), 32'b0010);
      tick();
      tick();
      req[1] = 1'b0;
      tick();
      chk("s5_rel_grant", 32'(grant), 32'd0);
      chk("s5_rel_done", 32'(done), 32'b0010);
      chk("s5_rel_value", disp_value, 32'h2222_2222);
      tick();
      tick();
      chk("s5_grant3", 32'(grant), 32'b1000);
      chk("s5_owner3", 32'(owner), 32'd3);
      $display("scenario 5: early drop");

      // Live data update, then reset mid-hold.
      do_reset();
      req_data[31:0] = 32'h0;
      req_mask[7:0]  = 8'hFF;
      req = 4'b0001;
      tick();
      tick();
      tick();
      req_data[31:0] = 32'h0000_1234;
      tick();
      chk("s6_live_value", disp_value, 32'h0000_1234);
      chk("s6_live_load", 32'(disp_load), 32'd1);
      tick();
      chk("s6_live_load_off", 32'(disp_load), 32'd0);
      reset = 1'b1;
      tick();
      chk("s6_rst_grant", 32'(grant), 32'd0);
      chk("s6_rst_done", 32'(done), 32'd0);
      chk("s6_rst_owner", 32'(owner), 32'd0);
      chk("s6_rst_value", disp_value, 32'd0);
      chk("s6_rst_mask", 32'(disp_mask), 32'd0);
      chk("s6_rst_load", 32'(disp_load), 32'd0);
      reset = 1'b0;
      req   = '0;
      tick();
      $display("scenario 6: live update and reset");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
